// File: rtl/mbus_tx_sequencer.sv
// Message FIFO plus word-at-a-time MBus transmit handshake sequencer.
// Words queued by the layer controller are sent as TX_REQ/TX_ACK pairs, then TX_SUCC/TX_FAIL is collected and acknowledged.
module mbus_tx_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    CLK_EXT,
    input  logic                    RESET,
    input  logic                    WR_EN,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    WR_LAST,
    input  logic [ADDR_WIDTH-1:0]   MSG_ADDR,
    input  logic                    MSG_PRIORITY,
    input  logic                    GO,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAILED,
    output logic [7:0]              WORDS_SENT,
    output logic [ADDR_WIDTH-1:0]   TX_ADDR,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_PEND,
    output logic                    TX_REQ,
    output logic                    TX_PRIORITY,
    output logic                    TX_RESP_ACK,
    input  logic                    TX_ACK,
    input  logic                    TX_SUCC,
    input  logic                    TX_FAIL
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_ACKLOW, S_RESP, S_RESPLOW, S_FLUSH
    } state_t;

    state_t state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] level_q, level_d;
    logic full_q, full_d, empty_q, empty_d, busy_q, busy_d;
    logic done_q, done_d, failed_q, failed_d;
    logic [7:0] words_sent_q, words_sent_d, stall_cnt_q, stall_cnt_d;
    logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic tx_pend_q, tx_pend_d, tx_req_q, tx_req_d, tx_prio_q, tx_prio_d;
    logic tx_resp_ack_q, tx_resp_ack_d;
    logic fail_seen_q, fail_seen_d, underrun_q, underrun_d, last_sent_q, last_sent_d;

    // Each entry holds {last, data}; storage is not reset, pointers are.
    logic [DATA_WIDTH:0] fifo_mem [DEPTH];
    logic [DATA_WIDTH:0] head;
    logic push, pop, abort;

    assign push = WR_EN && !full_q;
    assign head = fifo_mem[rd_ptr_q];

    always_ff @(posedge CLK_EXT) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {WR_LAST, WR_DATA};
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_addr_d     = tx_addr_q;
        tx_data_d     = tx_data_q;
        tx_pend_d     = tx_pend_q;
        tx_req_d      = tx_req_q;
        tx_prio_d     = tx_prio_q;
        tx_resp_ack_d = tx_resp_ack_q;
        words_sent_d  = words_sent_q;
        stall_cnt_d   = stall_cnt_q;
        fail_seen_d   = fail_seen_q;
        underrun_d    = underrun_q;
        last_sent_d   = last_sent_q;
        failed_d      = failed_q;
        done_d        = 1'b0;
        pop           = 1'b0;
        // TX_SUCC is only legitimate once the last word has been handed over.
        abort = TX_FAIL || (TX_SUCC && !(state_q == S_ACKLOW && last_sent_q));

        case (state_q)
            S_IDLE: begin
                if (GO && !empty_q) begin
                    tx_addr_d    = MSG_ADDR;
                    tx_prio_d    = MSG_PRIORITY;
                    words_sent_d = 8'd0;
                    stall_cnt_d  = 8'd0;
                    fail_seen_d  = 1'b0;
                    underrun_d   = 1'b0;
                    last_sent_d  = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    tx_req_d    = 1'b0;
                    tx_pend_d   = 1'b0;
                    fail_seen_d = 1'b1;
                    state_d     = S_RESP;
                end else if (!empty_q) begin
                    pop         = 1'b1;
                    tx_data_d   = head[DATA_WIDTH-1:0];
                    tx_pend_d   = !head[DATA_WIDTH];
                    last_sent_d = head[DATA_WIDTH];
                    tx_req_d    = 1'b1;
                    stall_cnt_d = 8'd0;
                    state_d     = S_REQ;
                end else if (stall_cnt_q == 8'd254) begin
                    underrun_d = 1'b1;
                    state_d    = S_FLUSH;
                end else begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
            end
            S_REQ, S_ACKLOW: begin
                if (abort) begin
                    tx_req_d    = 1'b0;
                    tx_pend_d   = 1'b0;
                    fail_seen_d = 1'b1;
                    state_d     = S_RESP;
                end else if (state_q == S_REQ && TX_ACK) begin
                    tx_req_d = 1'b0;
                    if (words_sent_q != 8'hFF) begin
                        words_sent_d = words_sent_q + 8'd1;
                    end
                    state_d = S_ACKLOW;
                end else if (state_q == S_ACKLOW && !TX_ACK) begin
                    state_d = last_sent_q ? S_RESP : S_LOAD;
                end
            end
            S_RESP: begin
                if (TX_SUCC || TX_FAIL) begin
                    tx_resp_ack_d = 1'b1;
                    fail_seen_d   = fail_seen_q || TX_FAIL;
                    state_d       = S_RESPLOW;
                end
            end
            S_RESPLOW: begin
                if (!TX_SUCC && !TX_FAIL) begin
                    tx_resp_ack_d = 1'b0;
                    if (!last_sent_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        done_d   = 1'b1;
                        failed_d = fail_seen_q || underrun_q;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (!empty_q) begin
                    pop = 1'b1;
                    if (head[DATA_WIDTH]) begin
                        done_d   = 1'b1;
                        failed_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            failed_q      <= 1'b0;
            words_sent_q  <= 8'd0;
            stall_cnt_q   <= 8'd0;
            tx_addr_q     <= '0;
            tx_data_q     <= '0;
            tx_pend_q     <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_prio_q     <= 1'b0;
            tx_resp_ack_q <= 1'b0;
            fail_seen_q   <= 1'b0;
            underrun_q    <= 1'b0;
            last_sent_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            failed_q      <= failed_d;
            words_sent_q  <= words_sent_d;
            stall_cnt_q   <= stall_cnt_d;
            tx_addr_q     <= tx_addr_d;
            tx_data_q     <= tx_data_d;
            tx_pend_q     <= tx_pend_d;
            tx_req_q      <= tx_req_d;
            tx_prio_q     <= tx_prio_d;
            tx_resp_ack_q <= tx_resp_ack_d;
            fail_seen_q   <= fail_seen_d;
            underrun_q    <= underrun_d;
            last_sent_q   <= last_sent_d;
        end
    end

    assign FULL        = full_q;
    assign EMPTY       = empty_q;
    assign LEVEL       = level_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign FAILED      = failed_q;
    assign WORDS_SENT  = words_sent_q;
    assign TX_ADDR     = tx_addr_q;
    assign TX_DATA     = tx_data_q;
    assign TX_PEND     = tx_pend_q;
    assign TX_REQ      = tx_req_q;
    assign TX_PRIORITY = tx_prio_q;
    assign TX_RESP_ACK = tx_resp_ack_q;
endmodule
